// File: rtl/mem_arbiter_cache_if.sv
// Bundles the consumer-side and memory-side request/response signals of mem_arbiter_cache.
// The arbiter uses the master view; consumers and the memory model use the slave view.
interface mem_arbiter_cache_if #(
   parameter int ADDR_BITS         = 8,
   parameter int CONSUMER_BUS_BITS = 8,
   parameter int NUM_CONSUMERS     = 4,
   parameter int NUM_CHANNELS      = 1,
   parameter int MEMORY_BUS_BITS   = 8
);
   logic [NUM_CONSUMERS-1:0]                   consumer_read_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0]         consumer_read_address;
   logic [NUM_CONSUMERS-1:0]                   consumer_read_ready;
   logic [NUM_CONSUMERS*CONSUMER_BUS_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]                   consumer_write_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0]         consumer_write_address;
   logic [NUM_CONSUMERS*CONSUMER_BUS_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]                   consumer_write_ready;

   logic [NUM_CHANNELS-1:0]                    mem_read_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]          mem_read_address;
   logic [NUM_CHANNELS-1:0]                    mem_read_ready;
   logic [NUM_CHANNELS*MEMORY_BUS_BITS-1:0]    mem_read_data;
   logic [NUM_CHANNELS-1:0]                    mem_write_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]          mem_write_address;
   logic [NUM_CHANNELS*MEMORY_BUS_BITS-1:0]    mem_write_data;
   logic [NUM_CHANNELS-1:0]                    mem_write_ready;

   modport master (
      input  consumer_read_valid, consumer_read_address,
      output consumer_read_ready, consumer_read_data,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_write_ready,
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   modport slave (
      output consumer_read_valid, consumer_read_address,
      input  consumer_read_ready, consumer_read_data,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/mem_arbiter_cache.sv
// Pass-through arbiter: each memory channel claims the lowest-index unclaimed requester,
// forwards one read or write to memory and relays the reply with a valid/ready handshake.
module mem_arbiter_cache #(
   parameter int ADDR_BITS         = 8,
   parameter int CONSUMER_BUS_BITS = 8,
   parameter int NUM_CONSUMERS     = 4,
   parameter int NUM_CHANNELS      = 1,
   parameter int MEMORY_BUS_BITS   = 8
) (
   input logic                 clk,
   input logic                 reset,
   mem_arbiter_cache_if.master bus
);
   typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} ch_state_t;
   localparam int ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   ch_state_t                                  state_reg [NUM_CHANNELS];
   ch_state_t                                  state_next [NUM_CHANNELS];
   logic [ID_BITS-1:0]                         id_reg [NUM_CHANNELS];
   logic [ID_BITS-1:0]                         id_next [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]                   claim_reg, claim_next, taken;
   logic                                       found;
   logic [NUM_CHANNELS-1:0]                    mem_rv_reg, mem_rv_next, mem_wv_reg, mem_wv_next;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]          mem_ra_reg, mem_ra_next, mem_wa_reg, mem_wa_next;
   logic [NUM_CHANNELS*MEMORY_BUS_BITS-1:0]    mem_wd_reg, mem_wd_next;
   logic [NUM_CONSUMERS-1:0]                   c_rr_reg, c_rr_next, c_wr_reg, c_wr_next;
   logic [NUM_CONSUMERS*CONSUMER_BUS_BITS-1:0] c_rd_reg, c_rd_next;

   logic [ADDR_BITS-1:0]         c_raddr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]         c_waddr [NUM_CONSUMERS];
   logic [CONSUMER_BUS_BITS-1:0] c_wdata [NUM_CONSUMERS];
   logic [MEMORY_BUS_BITS-1:0]   m_rdata [NUM_CHANNELS];

   for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_consumer
      assign c_raddr[gi] = bus.consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign c_waddr[gi] = bus.consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign c_wdata[gi] = bus.consumer_write_data[gi*CONSUMER_BUS_BITS +: CONSUMER_BUS_BITS];
   end

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
      assign m_rdata[gi] = bus.mem_read_data[gi*MEMORY_BUS_BITS +: MEMORY_BUS_BITS];
   end

   always_comb begin
      claim_next  = claim_reg;
      taken       = claim_reg;
      found       = 1'b0;
      mem_rv_next = mem_rv_reg;
      mem_ra_next = mem_ra_reg;
      mem_wv_next = mem_wv_reg;
      mem_wa_next = mem_wa_reg;
      mem_wd_next = mem_wd_reg;
      c_rr_next   = c_rr_reg;
      c_rd_next   = c_rd_reg;
      c_wr_next   = c_wr_reg;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         state_next[ch] = state_reg[ch];
         id_next[ch]    = id_reg[ch];
      end
      // Channels resolve in index order; taken accumulates this cycle's claims so no consumer is picked twice.
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         found = 1'b0;
         case (state_reg[ch])
            IDLE: begin
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  if (!found && !taken[k] && (bus.consumer_read_valid[k] || bus.consumer_write_valid[k])) begin
                     found         = 1'b1;
                     taken[k]      = 1'b1;
                     claim_next[k] = 1'b1;
                     id_next[ch]   = ID_BITS'(k);
                     if (bus.consumer_read_valid[k]) begin
                        mem_rv_next[ch]                        = 1'b1;
                        mem_ra_next[ch*ADDR_BITS +: ADDR_BITS] = c_raddr[k];
                        state_next[ch]                         = READ_WAIT;
                     end else begin
                        mem_wv_next[ch]                                    = 1'b1;
                        mem_wa_next[ch*ADDR_BITS +: ADDR_BITS]             = c_waddr[k];
                        mem_wd_next[ch*MEMORY_BUS_BITS +: MEMORY_BUS_BITS] = c_wdata[k];
                        state_next[ch]                                     = WRITE_WAIT;
                     end
                  end
               end
            end
            READ_WAIT: begin
               if (bus.mem_read_ready[ch]) begin
                  mem_rv_next[ch]         = 1'b0;
                  c_rr_next[id_reg[ch]]   = 1'b1;
                  c_rd_next[int'(id_reg[ch])*CONSUMER_BUS_BITS +: CONSUMER_BUS_BITS] = m_rdata[ch];
                  state_next[ch]          = READ_RELAY;
               end
            end
            WRITE_WAIT: begin
               if (bus.mem_write_ready[ch]) begin
                  mem_wv_next[ch]       = 1'b0;
                  c_wr_next[id_reg[ch]] = 1'b1;
                  state_next[ch]        = WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!bus.consumer_read_valid[id_reg[ch]]) begin
                  c_rr_next[id_reg[ch]]  = 1'b0;
                  claim_next[id_reg[ch]] = 1'b0;
                  state_next[ch]         = IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!bus.consumer_write_valid[id_reg[ch]]) begin
                  c_wr_next[id_reg[ch]]  = 1'b0;
                  claim_next[id_reg[ch]] = 1'b0;
                  state_next[ch]         = IDLE;
               end
            end
            default: state_next[ch] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_reg[ch] <= IDLE;
            id_reg[ch]    <= '0;
         end
         claim_reg  <= '0;
         mem_rv_reg <= '0;
         mem_ra_reg <= '0;
         mem_wv_reg <= '0;
         mem_wa_reg <= '0;
         mem_wd_reg <= '0;
         c_rr_reg   <= '0;
         c_rd_reg   <= '0;
         c_wr_reg   <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_reg[ch] <= state_next[ch];
            id_reg[ch]    <= id_next[ch];
         end
         claim_reg  <= claim_next;
         mem_rv_reg <= mem_rv_next;
         mem_ra_reg <= mem_ra_next;
         mem_wv_reg <= mem_wv_next;
         mem_wa_reg <= mem_wa_next;
         mem_wd_reg <= mem_wd_next;
         c_rr_reg   <= c_rr_next;
         c_rd_reg   <= c_rd_next;
         c_wr_reg   <= c_wr_next;
      end
   end

   assign bus.mem_read_valid       = mem_rv_reg;
   assign bus.mem_read_address     = mem_ra_reg;
   assign bus.mem_write_valid      = mem_wv_reg;
   assign bus.mem_write_address    = mem_wa_reg;
   assign bus.mem_write_data       = mem_wd_reg;
   assign bus.consumer_read_ready  = c_rr_reg;
   assign bus.consumer_read_data   = c_rd_reg;
   assign bus.consumer_write_ready = c_wr_reg;
endmodule

// File: tb/tb_mem_arbiter_cache.sv
// Randomized scoreboard bench for mem_arbiter_cache with 4 consumers on 2 channels.
// Each consumer owns the address region addr[7:6]==id, so expected read data follows from its own history.
module tb_mem_arbiter_cache;
   localparam int AB   = 8;
   localparam int DB   = 8;
   localparam int NC   = 4;
   localparam int NCH  = 2;
   localparam int NOPS = 25;
   localparam int WAIT_BUDGET = 1000;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   logic [DB-1:0]    ref_mem [256];
   logic [DB-1:0]    sim_mem [256];
   logic [DB-1:0]    exp_rd [NC][$];
   logic [AB-1:0]    exp_ra [NC][$];
   logic [AB+DB-1:0] exp_wr [NC][$];
   int               wr_done [NC];
   int               wr_ack [NC];
   logic [AB-1:0]    first_ra [NC];

   always #5 clk = ~clk;

   mem_arbiter_cache_if #(.ADDR_BITS(AB), .CONSUMER_BUS_BITS(DB), .NUM_CONSUMERS(NC),
                          .NUM_CHANNELS(NCH), .MEMORY_BUS_BITS(DB)) bus ();

   mem_arbiter_cache #(.ADDR_BITS(AB), .CONSUMER_BUS_BITS(DB), .NUM_CONSUMERS(NC),
                       .NUM_CHANNELS(NCH), .MEMORY_BUS_BITS(DB)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Waits for the consumer's ready, drops valid, then requires ready to fall one cycle later.
   task automatic wait_ack(input int k, input bit is_write);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      while (!got && n < WAIT_BUDGET) begin
         @(posedge clk);
         #1;
         n++;
         got = is_write ? bus.consumer_write_ready[k] : bus.consumer_read_ready[k];
      end
      check(is_write ? "wr_ack_seen" : "rd_ack_seen", 32'(got), 1);
      if (is_write) bus.consumer_write_valid[k] = 1'b0;
      else          bus.consumer_read_valid[k]  = 1'b0;
      @(posedge clk);
      #1;
      if (is_write) check("wr_ready_drop", 32'(bus.consumer_write_ready[k]), 0);
      else          check("rd_ready_drop", 32'(bus.consumer_read_ready[k]), 0);
   endtask

   task automatic consumer_proc(input int k);
      logic [1:0]    kid;
      logic [AB-1:0] a_r, a_w;
      logic [DB-1:0] d_w;
      int            kind;
      kid = 2'(k);
      for (int op = 0; op < NOPS; op++) begin
         if (op == 0) begin
            kind = 0;
         end else begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            kind = $urandom_range(0, 2);
         end
         a_r = {kid, 6'($urandom)};
         a_w = ($urandom_range(0, 1) == 1) ? a_r : {kid, 6'($urandom)};
         d_w = 8'($urandom);
         if (op == 0) first_ra[k] = a_r;
         if (kind != 1) begin
            exp_rd[k].push_back(ref_mem[a_r]);
            exp_ra[k].push_back(a_r);
            bus.consumer_read_address[k*AB +: AB] = a_r;
            bus.consumer_read_valid[k] = 1'b1;
         end
         if (kind != 0) begin
            exp_wr[k].push_back({a_w, d_w});
            ref_mem[a_w] = d_w;
            bus.consumer_write_address[k*AB +: AB] = a_w;
            bus.consumer_write_data[k*DB +: DB]    = d_w;
            bus.consumer_write_valid[k] = 1'b1;
         end
         if (kind != 1) wait_ack(k, 1'b0);
         if (kind != 0) wait_ack(k, 1'b1);
      end
   endtask

   // External memory: answers each request after a random 0..4 cycle delay.
   initial begin : memory_model
      int            rd_cnt [NCH];
      int            wr_cnt [NCH];
      logic [AB-1:0] a;
      logic [DB-1:0] d;
      logic [AB+DB-1:0] e;
      logic [1:0]    r;
      logic          act [NCH];
      logic [1:0]    rg [NCH];
      bus.mem_read_ready  = '0;
      bus.mem_read_data   = '0;
      bus.mem_write_ready = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         rd_cnt[ch] = $urandom_range(0, 4);
         wr_cnt[ch] = $urandom_range(0, 4);
      end
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < NCH; ch++) begin
            act[ch] = bus.mem_read_valid[ch] || bus.mem_write_valid[ch];
            rg[ch]  = bus.mem_read_valid[ch] ? bus.mem_read_address[ch*AB+6 +: 2]
                                             : bus.mem_write_address[ch*AB+6 +: 2];
            if (bus.mem_read_ready[ch]) begin
               bus.mem_read_ready[ch] = 1'b0;
            end else if (bus.mem_read_valid[ch]) begin
               if (rd_cnt[ch] == 0) begin
                  a = bus.mem_read_address[ch*AB +: AB];
                  r = a[7:6];
                  check("mem_rd_pending", 32'(exp_ra[r].size() > 0), 1);
                  if (exp_ra[r].size() > 0) check("mem_rd_addr", a, exp_ra[r].pop_front());
                  bus.mem_read_data[ch*DB +: DB] = sim_mem[a];
                  bus.mem_read_ready[ch] = 1'b1;
                  rd_cnt[ch] = $urandom_range(0, 4);
               end else begin
                  rd_cnt[ch]--;
               end
            end
            if (bus.mem_write_ready[ch]) begin
               bus.mem_write_ready[ch] = 1'b0;
            end else if (bus.mem_write_valid[ch]) begin
               if (wr_cnt[ch] == 0) begin
                  a = bus.mem_write_address[ch*AB +: AB];
                  d = bus.mem_write_data[ch*DB +: DB];
                  r = a[7:6];
                  check("mem_wr_pending", 32'(exp_wr[r].size() > 0), 1);
                  if (exp_wr[r].size() > 0) begin
                     e = exp_wr[r].pop_front();
                     check("mem_wr_addr", a, e[15:8]);
                     check("mem_wr_data", d, e[7:0]);
                  end
                  sim_mem[a] = d;
                  wr_done[r]++;
                  bus.mem_write_ready[ch] = 1'b1;
                  wr_cnt[ch] = $urandom_range(0, 4);
               end else begin
                  wr_cnt[ch]--;
               end
            end
         end
         for (int i = 0; i < NCH; i++)
            for (int j = i + 1; j < NCH; j++)
               if (act[i] && act[j]) check("distinct_claim", 32'(rg[i] != rg[j]), 1);
      end
   end

   initial begin : consumer_monitor
      logic [NC-1:0] prev_rr;
      logic [NC-1:0] prev_wr;
      logic [DB-1:0] e;
      prev_rr = '0;
      prev_wr = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NC; k++) begin
            if (bus.consumer_read_ready[k] && !prev_rr[k]) begin
               check("rd_pending", 32'(exp_rd[k].size() > 0), 1);
               if (exp_rd[k].size() > 0) begin
                  e = exp_rd[k].pop_front();
                  check("rd_data", bus.consumer_read_data[k*DB +: DB], e);
                  $display("rd c%0d data 0x%02h exp 0x%02h", k, bus.consumer_read_data[k*DB +: DB], e);
               end
            end
            if (bus.consumer_write_ready[k] && !prev_wr[k]) begin
               wr_ack[k]++;
               check("wr_ack_order", wr_ack[k], wr_done[k]);
               $display("wr c%0d ack #%0d", k, wr_ack[k]);
            end
         end
         prev_rr = bus.consumer_read_ready;
         prev_wr = bus.consumer_write_ready;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [DB-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         ref_mem[i] = v;
         sim_mem[i] = v;
      end
      for (int k = 0; k < NC; k++) begin
         wr_done[k] = 0;
         wr_ack[k]  = 0;
      end
      bus.consumer_read_valid    = '0;
      bus.consumer_read_address  = '0;
      bus.consumer_write_valid   = '0;
      bus.consumer_write_address = '0;
      bus.consumer_write_data    = '0;
      reset = 1'b0;
      for (int k = 0; k < NC; k++) begin
         fork
            automatic int kk = k;
            consumer_proc(kk);
         join_none
      end
      repeat (3) @(negedge clk);
      check("rst_mem_read_valid", 32'(bus.mem_read_valid), 0);
      check("rst_mem_write_valid", 32'(bus.mem_write_valid), 0);
      check("rst_mem_read_address", 32'(bus.mem_read_address), 0);
      check("rst_consumer_read_ready", 32'(bus.consumer_read_ready), 0);
      check("rst_consumer_write_ready", 32'(bus.consumer_write_ready), 0);
      check("rst_consumer_read_data", bus.consumer_read_data, 0);
      reset = 1'b1;
      @(negedge clk);
      check("first_claim_valid", 32'(bus.mem_read_valid), 32'b11);
      check("first_claim_addr", 32'(bus.mem_read_address), {16'b0, first_ra[1], first_ra[0]});
      wait fork;
      repeat (6) @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         check("rd_queue_drained", exp_rd[k].size(), 0);
         check("wr_queue_drained", exp_wr[k].size(), 0);
         check("wr_ack_total", wr_ack[k], wr_done[k]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_cache.md
Name: mem_arbiter_cache

Overview:
- Multi-consumer to multi-channel memory request arbiter.
- Sits between N requesters (per-thread LSUs or per-core fetchers) and an external async memory exposing NUM_CHANNELS independent read/write channels.
- Each channel independently claims one pending consumer request, forwards it to memory, and relays the response back using a valid/ready handshake.
- No data is retained between transactions: every request goes to memory (pass-through).

Parameters:
- ADDR_BITS, 8, address width for both consumer and memory sides.
- CONSUMER_BUS_BITS, 8, consumer data width.
- NUM_CONSUMERS, 4, number of requesters.
- NUM_CHANNELS, 1, number of concurrent memory channels; must be 1..NUM_CONSUMERS.
- MEMORY_BUS_BITS, 8, memory data width; must equal CONSUMER_BUS_BITS.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer k at [k*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  read response valid.
- consumer_read_data  out  NUM_CONSUMERS*CONSUMER_BUS_BITS  packed read data.
- consumer_write_valid  in  NUM_CONSUMERS  write request; tie to 0 for read-only use.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  in  NUM_CONSUMERS*CONSUMER_BUS_BITS  packed.
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledge.
- mem_read_valid  out  NUM_CHANNELS  read request to memory.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed.
- mem_read_ready  in  NUM_CHANNELS  memory read response valid.
- mem_read_data  in  NUM_CHANNELS*MEMORY_BUS_BITS  packed.
- mem_write_valid  out  NUM_CHANNELS  write request to memory.
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed.
- mem_write_data  out  NUM_CHANNELS*MEMORY_BUS_BITS  packed.
- mem_write_ready  in  NUM_CHANNELS  memory write acknowledge.

Behaviour:
- Reset (reset=0, async): all outputs 0, every channel in IDLE, claim mask cleared. Reset mid-transaction abandons it; the consumer must re-request.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- One global claim bit per consumer; a claimed consumer is invisible to the other channels.

IDLE arbitration:
- Scan consumers from index 0 upward; select the lowest index with (read_valid or write_valid) and claim bit clear.
- Read has priority over write for the same consumer.
- Channels are evaluated in index order within one cycle, so two channels never claim the same consumer; lower channel gets the lower consumer.
- On claim: set claim bit and record consumer id. For a read, drive mem_read_valid=1 with that consumer's address next cycle and go to READ_WAIT. For a write, drive mem_write_valid=1 with its address/data and go to WRITE_WAIT.

Transaction states:
- READ_WAIT: hold request until mem_read_ready=1. Then mem_read_valid<=0, consumer_read_ready[id]<=1, consumer_read_data[id]<=mem_read_data; go to READ_RELAY.
- WRITE_WAIT: hold until mem_write_ready=1. Then mem_write_valid<=0, consumer_write_ready[id]<=1; go to WRITE_RELAY.
- READ_RELAY / WRITE_RELAY: hold ready until the consumer's corresponding valid is 0. Then ready<=0, claim bit cleared, go to IDLE. The consumer may be re-claimed on the cycle after IDLE is reached.
- consumer_read_data holds its last value after ready drops.

Timing and limits:
- Minimum latency: request seen at edge 0, mem valid at edge 1; memory ready at edge 1 gives consumer ready at edge 2.
- No limit on memory wait cycles.
- Unclaimed consumers simply wait; starvation of high indices is allowed.
- Consumer address/data must be stable while its valid is high; they are sampled at claim.

Test Plan:
- Reset: hold reset=0 with valid inputs → all outputs 0; release, first claim occurs on the following edge.
- Single read: consumer 2 reads addr 0x10, memory returns 0x5A after 3 cycles → mem_read_address=0x10; consumer_read_ready[2]=1 with data 0x5A; ready drops 1 cycle after valid drops.
- Single write: consumer 0 writes 0xAB to 0x20 → mem_write_valid with 0x20/0xAB; consumer_write_ready[0]=1 after mem_write_ready.
- Contention, 1 channel: consumers 1 and 3 read simultaneously → consumer 1 served fully first, then consumer 3; never both mem valid at once.
- Multi-channel (2 channels, 4 consumers all reading) → ch0 takes c0 and ch1 takes c1 in the same cycle; no duplicate claims; all four complete with correct data.
- Read+write on the same consumer at once → read served first, write on the next claim.
